// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map, STATUS/CTRL bit positions and FSM encoding for spi_host_ctrl
package spi_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CLKDIV = 2'd3;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_ACTIVE   = 4;
    localparam int STAT_TX_OVF   = 5;
    localparam int STAT_RX_OVF   = 6;

    localparam int CTRL_CPOL    = 0;
    localparam int CTRL_CPHA    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_SLV_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_fifo.sv
// rtl/spi_fifo.sv - synchronous FIFO; a push into a full FIFO is accepted when a pop happens the same cycle
module spi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_host_ctrl.sv
// rtl/spi_host_ctrl.sv - register front end feeding an SPI core through TX/RX FIFOs; SPI_IRQ_EN enables irq
module spi_host_ctrl
    import spi_pkg::*;
#(
    parameter int D_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SLAVES     = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [1:0]         addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] rdata,
    output logic               core_enable,
    output logic               core_cpol,
    output logic               core_cpha,
    output logic               core_cont,
    output logic [7:0]         core_clk_div,
    output logic [7:0]         core_addr,
    output logic [D_WIDTH-1:0] core_tx_data,
    input  logic               core_busy,
    input  logic [D_WIDTH-1:0] core_rx_data,
    output logic               irq
);

    if (SLAVES < 1 || SLAVES > 16 || D_WIDTH < 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("spi_host_ctrl: illegal parameter combination");
    end

    state_t             state;
    state_t             state_nxt;
    logic               tx_pop;
    logic               rx_push;
    logic               tx_full, tx_empty, rx_full, rx_empty;
    logic [D_WIDTH-1:0] tx_head, rx_head;
    logic               tx_ovf, rx_ovf;
    logic               ctrl_cpol, ctrl_cpha, irq_en_rd;
    logic [3:0]         ctrl_slave;
    logic [7:0]         clk_div;
    logic               wr_data, rd_data, wr_status;
    logic               tx_ovf_evt, rx_ovf_evt;
    logic [D_WIDTH-1:0] rd_mux;

    assign wr_data   = wr_en && (addr == ADDR_DATA);
    assign rd_data   = rd_en && (addr == ADDR_DATA);
    assign wr_status = wr_en && (addr == ADDR_STATUS);

    spi_fifo #(.WIDTH(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (wr_data),
        .push_data (wdata),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_fifo #(.WIDTH(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rx_push),
        .push_data (core_rx_data),
        .pop       (rd_data),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // A same-cycle pop frees the slot, so only an unrelieved full FIFO overflows.
    assign tx_ovf_evt = wr_data && tx_full && !tx_pop;
    assign rx_ovf_evt = rx_push && rx_full && !rd_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        core_enable = 1'b0;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!tx_empty && !core_busy) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                core_enable = 1'b1;
                tx_pop      = 1'b1;
                state_nxt   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (core_busy) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!core_busy) begin
                    rx_push   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign core_tx_data = tx_head;
    assign core_cpol    = ctrl_cpol;
    assign core_cpha    = ctrl_cpha;
    assign core_cont    = 1'b0;
    assign core_clk_div = clk_div;
    assign core_addr    = {4'b0000, ctrl_slave};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_cpol  <= 1'b0;
            ctrl_cpha  <= 1'b0;
            ctrl_slave <= 4'd0;
            clk_div    <= 8'd0;
        end else if (wr_en) begin
            if (addr == ADDR_CTRL) begin
                ctrl_cpol  <= wdata[CTRL_CPOL];
                ctrl_cpha  <= wdata[CTRL_CPHA];
                ctrl_slave <= wdata[CTRL_SLV_LSB +: 4];
            end
            if (addr == ADDR_CLKDIV) clk_div <= wdata[7:0];
        end
    end

    // Clear-on-write first, so a new overflow in the same cycle still sticks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (wr_status) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (tx_ovf_evt) tx_ovf <= 1'b1;
            if (rx_ovf_evt) rx_ovf <= 1'b1;
        end
    end

`ifdef SPI_IRQ_EN
    logic ctrl_irq_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                       ctrl_irq_en <= 1'b0;
        else if (wr_en && addr == ADDR_CTRL) ctrl_irq_en <= wdata[CTRL_IRQ_EN];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= (ctrl_irq_en && !rx_empty) || tx_ovf || rx_ovf;
    end

    assign irq_en_rd = ctrl_irq_en;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DATA: begin
                if (!rx_empty) rd_mux = rx_head;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_TX_FULL]  = tx_full;
                rd_mux[STAT_TX_EMPTY] = tx_empty;
                rd_mux[STAT_RX_FULL]  = rx_full;
                rd_mux[STAT_RX_EMPTY] = rx_empty;
                rd_mux[STAT_ACTIVE]   = (state != ST_IDLE);
                rd_mux[STAT_TX_OVF]   = tx_ovf;
                rd_mux[STAT_RX_OVF]   = rx_ovf;
            end
            ADDR_CTRL: begin
                rd_mux[CTRL_CPOL]            = ctrl_cpol;
                rd_mux[CTRL_CPHA]            = ctrl_cpha;
                rd_mux[CTRL_IRQ_EN]          = irq_en_rd;
                rd_mux[CTRL_SLV_LSB +: 4]    = ctrl_slave;
            end
            default: rd_mux[7:0] = clk_div;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   rdata <= '0;
        else if (rd_en) rdata <= rd_mux;
    end

endmodule

// File: doc/spi_host_ctrl.md
SPI_HOST_CTRL -- requirements
Module: spi_host_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, meaning SPI word width and CPU data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning TX and RX FIFO entries each (power of two, >=2).
REQ-003 SHALL have parameter SLAVES, default 1, meaning number of selectable slaves.
REQ-004 SHALL have ports: clock in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have CPU ports: wr_en in 1, write strobe; rd_en in 1, read strobe; addr in 2, register select; wdata in D_WIDTH, write data; rdata out D_WIDTH, read data.
REQ-006 SHALL have core-side ports: core_enable out 1, start pulse; core_cpol out 1; core_cpha out 1; core_cont out 1; core_clk_div out 8; core_addr out 8, slave index; core_tx_data out D_WIDTH; core_busy in 1; core_rx_data in D_WIDTH.
REQ-007 SHALL have irq out 1, interrupt request.

Function
REQ-010 Register map SHALL be: 0 DATA (write pushes TX FIFO, read pops RX FIFO); 1 STATUS; 2 CTRL; 3 CLKDIV.
REQ-011 STATUS SHALL be: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 active, bit5 tx_ovf (sticky), bit6 rx_ovf (sticky); write to STATUS with any data SHALL clear bits 5-6.
REQ-012 CTRL SHALL be: bit0 cpol, bit1 cpha, bit2 irq_en, bits 7:4 slave index; core_cpol/core_cpha/core_addr SHALL reflect CTRL directly.
REQ-013 CLKDIV SHALL drive core_clk_div directly; core_cont SHALL be tied 0.
REQ-014 rdata SHALL be registered: value valid the cycle after rd_en; rdata SHALL hold when rd_en low.
REQ-015 Write to DATA with TX FIFO full SHALL be dropped and set tx_ovf; read of DATA with RX FIFO empty SHALL return 0 and not pop.
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE->LAUNCH when TX not empty and core_busy==0; RX full does not block launch.
REQ-018 LAUNCH SHALL assert core_enable for exactly one cycle with core_tx_data = TX head, pop TX, go to WAIT_BUSY.
REQ-019 WAIT_BUSY->WAIT_DONE when core_busy==1; WAIT_DONE->IDLE when core_busy==0, pushing core_rx_data into RX FIFO that same cycle.
REQ-020 Push to full RX FIFO SHALL discard the word and set rx_ovf.
REQ-021 active SHALL be 1 in any state other than IDLE.
REQ-022 Simultaneous CPU push and FSM pop on TX (or CPU pop and FSM push on RX) SHALL both take effect; a full FIFO popped and pushed the same cycle SHALL accept the push without overflow.
REQ-023 Back-to-back words SHALL launch from IDLE the cycle after busy falls, with no CPU intervention.
REQ-024 CTRL/CLKDIV writes while active SHALL take effect immediately (software's responsibility to avoid).

Reset
REQ-030 reset_n low SHALL asynchronously set: FSM IDLE, both FIFOs empty, sticky flags 0, CTRL 0, CLKDIV 0, rdata 0, core_enable 0, irq 0.
REQ-031 After reset release, no launch SHALL occur until core_busy is sampled 0 (core holds busy high through its reset).
REQ-032 Reset mid-transfer SHALL abandon the word; nothing is pushed to RX.

Configuration
REQ-040 With SPI_IRQ_EN defined, irq SHALL be registered (irq_en & ~rx_empty) | tx_ovf | rx_ovf.
REQ-041 Without SPI_IRQ_EN, irq SHALL be constant 0 and CTRL bit2 SHALL read 0.

Structure
REQ-050 Package spi_pkg SHALL hold register addresses, STATUS/CTRL bit positions and FSM state encoding.
REQ-051 Sub-module spi_fifo (synchronous, parameterised width/depth, full/empty flags, simultaneous push/pop) SHALL be instantiated twice.

Verification
REQ-060 Write 0xA5 to DATA with core model echoing -> one core_enable pulse, core_tx_data=0xA5; after busy falls, read DATA returns echoed word, STATUS bit3=1.
REQ-061 Write 5 words with FIFO_DEPTH=4 while core held busy -> 5th dropped, STATUS bit5=1; write STATUS -> bit5=0.
REQ-062 Queue 4 words, core busy 10 cycles each -> 4 launches, each 1 cycle after busy falls; RX reads return order sent.
REQ-063 Fill RX (4 words unread), send 5th -> rx_ovf=1, first 4 words intact.
REQ-064 Assert reset_n low during WAIT_DONE -> all outputs reset values, FIFOs empty; no launch until core_busy=0.
REQ-065 SPI_IRQ_EN defined, CTRL=0x04, one transfer -> irq rises after RX push, falls after DATA read.
